// File: rtl/baby_kyber_pkg.sv
// Shared Baby-Kyber parameters (q=17, n=4, k=2), coefficient types and modular reduction.
// Used by key generation and encryption.
package baby_kyber_pkg;
  localparam int Q      = 17;
  localparam int N      = 4;
  localparam int K      = 2;
  localparam int Q_HALF = 9;
  localparam int COEF_W = 32;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [N-1:0]            poly_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_FIN,
    S_DONE
  } enc_state_t;

  // Floor modulo: result always lands in [0, Q-1], negatives wrap upward.
  function automatic coef_t mod_q(coef_t x);
    coef_t rem;
    rem = x % coef_t'(Q);
    if (rem < 0) rem = rem + coef_t'(Q);
    return rem;
  endfunction
endpackage

// File: rtl/negacyclic_coef_mac.sv
// One coefficient of a0*b0 + a1*b1 in Z[x]/(x^4+1) from canonical operands.
// Purely combinational; the result is signed and not yet reduced.
module negacyclic_coef_mac
  import baby_kyber_pkg::*;
(
  input  logic [N-1:0][4:0]  a0_i,
  input  logic [N-1:0][4:0]  b0_i,
  input  logic [N-1:0][4:0]  a1_i,
  input  logic [N-1:0][4:0]  b1_i,
  input  logic [1:0]         c_i,
  output logic signed [12:0] sum_o
);

  logic [1:0]         j;
  logic signed [12:0] p0;
  logic signed [12:0] p1;

  always_comb begin
    sum_o = '0;
    j     = '0;
    p0    = '0;
    p1    = '0;
    for (int i = 0; i < N; i++) begin
      j  = c_i - 2'(i);
      p0 = {8'd0, a0_i[i]} * {8'd0, b0_i[j]};
      p1 = {8'd0, a1_i[i]} * {8'd0, b1_i[j]};
      // Terms that wrap past x^3 pick up the -1 from x^4 = -1.
      if (2'(i) > c_i) sum_o = sum_o - p0 - p1;
      else             sum_o = sum_o + p0 + p1;
    end
  end

endmodule

// File: rtl/kyber_encrypt.sv
// Baby-Kyber encryption: u = A^T r + e1, v = t^T r + e2 + 9m over Z17[x]/(x^4+1).
// One shared MAC produces one coefficient per cycle; 13-cycle latency, result held until out_ready.
module kyber_encrypt
  import baby_kyber_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [3:0][3:0][COEF_W-1:0]    pk_a,
  input  logic [1:0][3:0][COEF_W-1:0]    pk_t,
  input  logic [1:0][3:0][COEF_W-1:0]    r,
  input  logic [1:0][3:0][COEF_W-1:0]    e1,
  input  logic [3:0][COEF_W-1:0]         e2,
  input  logic [3:0]                     msg,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [1:0][3:0][COEF_W-1:0]    u,
  output logic [3:0][COEF_W-1:0]         v
);

  enc_state_t                  state_q;
  logic [3:0]                  idx_q;
  logic [3:0][N-1:0][4:0]      a_q;
  logic [1:0][N-1:0][4:0]      t_q;
  logic [1:0][N-1:0][4:0]      r_q;
  logic [1:0][N-1:0][4:0]      e1_q;
  logic [N-1:0][4:0]           e2_q;
  logic [3:0]                  msg_q;
  logic [11:0][4:0]            res_q;
  logic                        out_valid_q;
  logic [1:0][3:0][COEF_W-1:0] u_q;
  logic [3:0][COEF_W-1:0]      v_q;

  logic [N-1:0][4:0]           op_a0;
  logic [N-1:0][4:0]           op_a1;
  logic signed [12:0]          mac_sum;
  logic [4:0]                  res_d;

  function automatic logic [4:0] canon(logic [COEF_W-1:0] x);
    return 5'(mod_q($signed(x)));
  endfunction

  // u_j takes column j of A (rows A0j, A1j); v takes t. All pair with r0, r1.
  always_comb begin
    op_a0 = t_q[0];
    op_a1 = t_q[1];
    case (idx_q[3:2])
      2'd0: begin
        op_a0 = a_q[0];
        op_a1 = a_q[2];
      end
      2'd1: begin
        op_a0 = a_q[1];
        op_a1 = a_q[3];
      end
      default: ;
    endcase
  end

  negacyclic_coef_mac u_mac (
    .a0_i  (op_a0),
    .b0_i  (r_q[0]),
    .a1_i  (op_a1),
    .b1_i  (r_q[1]),
    .c_i   (idx_q[1:0]),
    .sum_o (mac_sum)
  );

  assign res_d = 5'(mod_q(coef_t'(mac_sum)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      t_q         <= '0;
      r_q         <= '0;
      e1_q        <= '0;
      e2_q        <= '0;
      msg_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      u_q         <= '0;
      v_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            for (int c = 0; c < N; c++) begin
              for (int i = 0; i < 4; i++) a_q[i][c] <= canon(pk_a[i][c]);
              for (int j = 0; j < K; j++) begin
                t_q[j][c]  <= canon(pk_t[j][c]);
                r_q[j][c]  <= canon(r[j][c]);
                e1_q[j][c] <= canon(e1[j][c]);
              end
              e2_q[c] <= canon(e2[c]);
            end
            msg_q   <= msg;
            idx_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          res_q[idx_q] <= res_d;
          idx_q        <= idx_q + 4'd1;
          if (idx_q == 4'd11) state_q <= S_FIN;
        end
        S_FIN: begin
          for (int c = 0; c < N; c++) begin
            for (int j = 0; j < K; j++)
              u_q[j][c] <= mod_q(coef_t'(res_q[4*j+c]) + coef_t'(e1_q[j][c]));
            v_q[c] <= mod_q(coef_t'(res_q[8+c]) + coef_t'(e2_q[c]) +
                            (msg_q[c] ? coef_t'(Q_HALF) : coef_t'(0)));
          end
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready = rst_n && (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign u           = u_q;
  assign v           = v_q;

endmodule

// File: tb/tb_kyber_encrypt.sv
// Directed and reference-model checks of kyber_encrypt: reset, products, reduction,
// backpressure hold, mid-run reset and latency.
module tb_kyber_encrypt;
  import baby_kyber_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        start_valid;
  logic                        start_ready;
  logic [3:0][3:0][31:0]       pk_a;
  logic [1:0][3:0][31:0]       pk_t;
  logic [1:0][3:0][31:0]       r;
  logic [1:0][3:0][31:0]       e1;
  logic [3:0][31:0]            e2;
  logic [3:0]                  msg;
  logic                        out_valid;
  logic                        out_ready;
  logic [1:0][3:0][31:0]       u;
  logic [3:0][31:0]            v;

  int ma[4][4];
  int mt[2][4];
  int mr[2][4];
  int me1[2][4];
  int me2[4];
  logic [3:0] mm;

  int total = 0;
  int bad   = 0;
  logic [1:0][3:0][31:0] eu;
  logic [3:0][31:0]      ev;

  always #5 clk = ~clk;

  kyber_encrypt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .pk_a        (pk_a),
    .pk_t        (pk_t),
    .r           (r),
    .e1          (e1),
    .e2          (e2),
    .msg         (msg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .u           (u),
    .v           (v)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_vec();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) ma[i][c] = 0;
      for (int j = 0; j < 2; j++) begin
        mt[j][c] = 0; mr[j][c] = 0; me1[j][c] = 0;
      end
      me2[c] = 0;
    end
    mm = 4'b0;
    eu = '0;
    ev = '0;
  endtask

  task automatic drive_vec();
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) pk_a[i][c] = ma[i][c];
      for (int j = 0; j < 2; j++) begin
        pk_t[j][c] = mt[j][c]; r[j][c] = mr[j][c]; e1[j][c] = me1[j][c];
      end
      e2[c] = me2[c];
    end
    msg = mm;
  endtask

  function automatic int fmod(int x);
    int m;
    m = x % 17;
    if (m < 0) m += 17;
    return m;
  endfunction

  // Schoolbook product then fold x^(4+k) -> -x^k.
  task automatic ref_model();
    int acc[3][4];
    int a;
    int k;
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < 4; c++) acc[p][c] = 0;
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) begin
            a = (p < 2) ? ma[2*s+p][i] : mt[s][i];
            k = i + j;
            if (k < 4) acc[p][k] += a * mr[s][j];
            else       acc[p][k-4] -= a * mr[s][j];
          end
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 2; j++) eu[j][c] = 32'(fmod(acc[j][c] + me1[j][c]));
      ev[c] = 32'(fmod(acc[2][c] + me2[c] + (mm[c] ? 9 : 0)));
    end
  endtask

  task automatic start_enc(input string tag);
    @(negedge clk);
    drive_vec();
    chk({tag, "_ready"}, 256'(start_ready), 256'(1));
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk({tag, "_lat"}, 256'(cyc), 256'(13));
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_u"}, 256'(u), 256'(eu));
    chk({tag, "_v"}, 256'(v), 256'(ev));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_ovld0"}, 256'(out_valid), 256'(0));
    chk({tag, "_srdy1"}, 256'(start_ready), 256'(1));
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; out_ready = 1'b0;
    clear_vec();
    drive_vec();
    #23;
    chk("rst_srdy", 256'(start_ready), 256'(0));
    chk("rst_ovld", 256'(out_valid), 256'(0));
    chk("rst_u", 256'(u), 256'(0));
    chk("rst_v", 256'(v), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    #1 chk("idle_srdy", 256'(start_ready), 256'(1));

    // All-zero operands, message 1010 -> v coefficients 1 and 3 carry 9.
    clear_vec();
    mm = 4'b1010;
    ev[1] = 32'd9; ev[3] = 32'd9;
    start_enc("zero");
    wait_done("zero");
    check_out("zero");
    handshake("zero");

    // x * x^3 = x^4 = -1 -> u0[0] = 16.
    clear_vec();
    ma[0][1] = 1; mr[0][3] = 1;
    eu[0][0] = 32'd16;
    start_enc("wrap");
    wait_done("wrap");
    check_out("wrap");
    handshake("wrap");

    // e1 = -1 wraps to 16; t coefficient 17 reduces to 0.
    clear_vec();
    me1[0][0] = -1; mt[0][2] = 17; mr[0][0] = 1;
    eu[0][0] = 32'd16;
    start_enc("red");
    wait_done("red");
    check_out("red");

    // Hold DONE with a competing start request; nothing may move.
    @(negedge clk);
    for (int c = 0; c < 4; c++) pk_a[0][c] = 32'(c + 3);
    msg = 4'b1111;
    start_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_out("hold");
      chk("hold_srdy", 256'(start_ready), 256'(0));
      chk("hold_ovld", 256'(out_valid), 256'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    start_valid = 1'b0;
    chk("hold_rel_ovld", 256'(out_valid), 256'(0));
    chk("hold_rel_srdy", 256'(start_ready), 256'(1));
    check_out("hold_rel");
    repeat (15) @(posedge clk);
    #1 chk("hold_nocap", 256'(out_valid), 256'(0));

    // Reset in the middle of the MAC phase discards everything.
    clear_vec();
    ma[0][1] = 1; mr[0][3] = 1;
    start_enc("mrst");
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ovld", 256'(out_valid), 256'(0));
    chk("mrst_u", 256'(u), 256'(0));
    chk("mrst_v", 256'(v), 256'(0));
    chk("mrst_srdy", 256'(start_ready), 256'(0));
    @(negedge clk) rst_n = 1'b1;
    #1 chk("mrst_idle", 256'(start_ready), 256'(1));
    eu[0][0] = 32'd16;
    start_enc("post");
    wait_done("post");
    check_out("post");
    handshake("post");

    // Random vectors against the schoolbook reference.
    for (int n = 0; n < 25; n++) begin
      clear_vec();
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 4; i++) ma[i][c] = int'($urandom_range(32)) - 16;
        for (int j = 0; j < 2; j++) begin
          mt[j][c]  = int'($urandom_range(32)) - 16;
          mr[j][c]  = int'($urandom_range(2)) - 1;
          me1[j][c] = int'($urandom_range(2)) - 1;
        end
        me2[c] = int'($urandom_range(2)) - 1;
      end
      mm = 4'($urandom_range(15));
      ref_model();
      start_enc("rnd");
      wait_done("rnd");
      check_out("rnd");
      handshake("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
